// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline hazard/forwarding logic.
// Holds the forwarding-mux select encodings, the hard-wired zero register
// address and the per-stage destination tag carried down the pipeline.
package pipe_pkg;

    localparam int TAG_ADDR_W = 5;

    localparam logic [1:0] FWD_SEL_REGFILE = 2'b00;
    localparam logic [1:0] FWD_SEL_EXMEM   = 2'b01;
    localparam logic [1:0] FWD_SEL_MEMWB   = 2'b10;

    localparam logic [TAG_ADDR_W-1:0] REG_ZERO = '0;

    typedef struct packed {
        logic                  v;
        logic [TAG_ADDR_W-1:0] rd;
        logic                  we;
    } stage_tag_t;

    // True when a stage will write a real, non-zero register equal to src.
    function automatic logic tag_hits(input stage_tag_t tag,
                                      input logic [TAG_ADDR_W-1:0] src);
        return tag.v && tag.we && (tag.rd != REG_ZERO) && (tag.rd == src);
    endfunction

endpackage

// File: rtl/fwd_sel_unit.sv
// Combinational select for one ALU-operand forwarding mux.
// Ports:
//   src_v    - instruction in EX is real; select is regfile otherwise
//   src      - source register address of that operand
//   mem_tag  - destination tag of the instruction in MEM (newer)
//   wb_tag   - destination tag of the instruction in WB (older)
//   sel      - 00 regfile, 01 EX/MEM result, 10 MEM/WB result
module fwd_sel_unit
    import pipe_pkg::*;
(
    input  logic                  src_v,
    input  logic [TAG_ADDR_W-1:0] src,
    input  stage_tag_t            mem_tag,
    input  stage_tag_t            wb_tag,
    output logic [1:0]            sel
);

    // MEM holds the younger producer, so it wins when both stages match.
    always_comb begin
        sel = FWD_SEL_REGFILE;
        if (src_v) begin
            if (tag_hits(mem_tag, src)) begin
                sel = FWD_SEL_EXMEM;
            end else if (tag_hits(wb_tag, src)) begin
                sel = FWD_SEL_MEMWB;
            end
        end
    end

endmodule

// File: rtl/fwd_hazard_ctrl.sv
// Forwarding and load-use hazard controller for the 5-stage pipeline.
// Tracks destination tags for EX, MEM and WB, drives the two operand
// forwarding selects and the stall/bubble controls.
// Optional build macro: FWDCTL_PERF_EN adds a saturating stall counter.
// Ports:
//   clk, rst_n         - pipeline clock, async active-low reset
//   id_valid           - ID holds a real instruction
//   id_rs, id_rt       - ID source registers
//   id_rd              - ID destination register
//   id_regwrite        - ID instruction writes the register file
//   id_memread         - ID instruction is a load
//   flush              - ID instruction is wrong-path
//   fwd_a_sel/fwd_b_sel- operand mux selects (00 rf, 01 EX/MEM, 10 MEM/WB)
//   stall              - load-use stall this cycle
//   pc_write/ifid_write- front-end write enables (~stall)
//   idex_bubble        - ID/EX loads a NOP (stall | flush)
//   stall_cnt          - stall cycle count (FWDCTL_PERF_EN only)
module fwd_hazard_ctrl
    import pipe_pkg::*;
#(
    parameter int REG_ADDR_W = TAG_ADDR_W
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  id_valid,
    input  logic [REG_ADDR_W-1:0] id_rs,
    input  logic [REG_ADDR_W-1:0] id_rt,
    input  logic [REG_ADDR_W-1:0] id_rd,
    input  logic                  id_regwrite,
    input  logic                  id_memread,
    input  logic                  flush,
    output logic [1:0]            fwd_a_sel,
    output logic [1:0]            fwd_b_sel,
    output logic                  stall,
    output logic                  pc_write,
    output logic                  ifid_write,
`ifdef FWDCTL_PERF_EN
    output logic [31:0]           stall_cnt,
`endif
    output logic                  idex_bubble
);

    logic                  ex_v;
    logic [REG_ADDR_W-1:0] ex_rs;
    logic [REG_ADDR_W-1:0] ex_rt;
    logic [REG_ADDR_W-1:0] ex_rd;
    logic                  ex_we;
    logic                  ex_ld;
    stage_tag_t            mem_tag;
    stage_tag_t            wb_tag;
    logic                  raw;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_v    <= 1'b0;
            ex_rs   <= '0;
            ex_rt   <= '0;
            ex_rd   <= '0;
            ex_we   <= 1'b0;
            ex_ld   <= 1'b0;
            mem_tag <= '0;
            wb_tag  <= '0;
        end else begin
            wb_tag  <= mem_tag;
            mem_tag <= '{v: ex_v, rd: ex_rd, we: ex_we};
            if (idex_bubble) begin
                ex_v  <= 1'b0;
                ex_rs <= '0;
                ex_rt <= '0;
                ex_rd <= '0;
                ex_we <= 1'b0;
                ex_ld <= 1'b0;
            end else begin
                ex_v  <= id_valid;
                ex_rs <= id_rs;
                ex_rt <= id_rt;
                ex_rd <= id_rd;
                ex_we <= id_regwrite;
                ex_ld <= id_memread;
            end
        end
    end

    fwd_sel_unit u_fwd_a (
        .src_v   (ex_v),
        .src     (ex_rs),
        .mem_tag (mem_tag),
        .wb_tag  (wb_tag),
        .sel     (fwd_a_sel)
    );

    fwd_sel_unit u_fwd_b (
        .src_v   (ex_v),
        .src     (ex_rt),
        .mem_tag (mem_tag),
        .wb_tag  (wb_tag),
        .sel     (fwd_b_sel)
    );

    // A load in EX cannot forward yet; hold the dependent instruction one
    // cycle. The inserted bubble clears ex_ld so the stall self-terminates.
    assign raw = ex_v && ex_ld && (ex_rd != REG_ZERO) && id_valid &&
                 ((ex_rd == id_rs) || (ex_rd == id_rt));

    assign stall       = raw && !flush;
    assign pc_write    = !stall;
    assign ifid_write  = !stall;
    assign idex_bubble = stall || flush;

`ifdef FWDCTL_PERF_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= '0;
        end else if (stall && (stall_cnt != 32'hFFFF_FFFF)) begin
            stall_cnt <= stall_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
module tb_fwd_hazard_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       id_valid;
    logic [4:0] id_rs, id_rt, id_rd;
    logic       id_regwrite, id_memread, flush;
    logic [1:0] fwd_a_sel, fwd_b_sel;
    logic       stall, pc_write, ifid_write, idex_bubble;
`ifdef FWDCTL_PERF_EN
    logic [31:0] stall_cnt;
`endif

    always #5 clk = ~clk;

    fwd_hazard_ctrl dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .id_valid    (id_valid),
        .id_rs       (id_rs),
        .id_rt       (id_rt),
        .id_rd       (id_rd),
        .id_regwrite (id_regwrite),
        .id_memread  (id_memread),
        .flush       (flush),
        .fwd_a_sel   (fwd_a_sel),
        .fwd_b_sel   (fwd_b_sel),
        .stall       (stall),
        .pc_write    (pc_write),
        .ifid_write  (ifid_write),
`ifdef FWDCTL_PERF_EN
        .stall_cnt   (stall_cnt),
`endif
        .idex_bubble (idex_bubble)
    );

    // Reference model: a list of in-flight instructions, index 0 = EX,
    // 1 = MEM, 2 = WB. Forwarding searches producers youngest-first.
    typedef struct {
        bit       v;
        bit [4:0] rs, rt, rd;
        bit       we, ld;
    } ins_t;

    ins_t        stg[3];
    ins_t        cur;
    bit          cur_fl;
    int unsigned model_stalls;
    int          passed = 0;
    int          total  = 0;

    function automatic ins_t mk(bit v, int rs, int rt, int rd, bit we, bit ld);
        ins_t i;
        i.v = v; i.rs = 5'(rs); i.rt = 5'(rt); i.rd = 5'(rd); i.we = we; i.ld = ld;
        return i;
    endfunction

    function automatic ins_t nop();
        return mk(0, 0, 0, 0, 0, 0);
    endfunction

    function automatic bit [1:0] m_sel(bit [4:0] src);
        if (!stg[0].v) return 2'd0;
        for (int s = 1; s <= 2; s++)
            if (stg[s].v && stg[s].we && stg[s].rd != 0 && stg[s].rd == src)
                return (s == 1) ? 2'd1 : 2'd2;
        return 2'd0;
    endfunction

    function automatic bit m_stall();
        bit dep;
        dep = (stg[0].rd == cur.rs) || (stg[0].rd == cur.rt);
        return stg[0].v && stg[0].ld && stg[0].rd != 0 && cur.v && dep && !cur_fl;
    endfunction

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    task automatic model_reset();
        for (int s = 0; s < 3; s++) stg[s] = nop();
        model_stalls = 0;
    endtask

    // Present one ID instruction half a cycle before the edge, check all
    // combinational outputs against the model, then clock it in.
    task automatic step(ins_t i, bit fl);
        bit st;
        @(negedge clk);
        cur = i; cur_fl = fl;
        id_valid = i.v; id_rs = i.rs; id_rt = i.rt; id_rd = i.rd;
        id_regwrite = i.we; id_memread = i.ld; flush = fl;
        #1;
        st = m_stall();
        chk("fwd_a",   32'(fwd_a_sel),   32'(m_sel(stg[0].rs)));
        chk("fwd_b",   32'(fwd_b_sel),   32'(m_sel(stg[0].rt)));
        chk("stall",   32'(stall),       32'(st));
        chk("pc_wr",   32'(pc_write),    32'(!st));
        chk("ifid_wr", 32'(ifid_write),  32'(!st));
        chk("bubble",  32'(idex_bubble), 32'(st | fl));
        @(posedge clk);
        if (st) model_stalls++;
        stg[2] = stg[1];
        stg[1] = stg[0];
        stg[0] = (st | fl) ? nop() : i;
    endtask

    task automatic idle(int n);
        for (int k = 0; k < n; k++) step(nop(), 0);
    endtask

    initial begin
        ins_t r;
        bit   held;
        rst_n = 1'b0;
        id_valid = 0; id_rs = 0; id_rt = 0; id_rd = 0;
        id_regwrite = 0; id_memread = 0; flush = 0;
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;

        // Reset state
        idle(2);
        chk("rst_a", 32'(fwd_a_sel), 32'd0);
        chk("rst_stall", 32'(stall), 32'd0);

        // EX/MEM forward, then MEM/WB forward with a spacer
        step(mk(1, 1, 2, 3, 1, 0), 0);
        step(mk(1, 3, 5, 4, 1, 0), 0);
        step(nop(), 0);
        chk("exmem_a", 32'(fwd_a_sel), 32'd1);
        chk("exmem_b", 32'(fwd_b_sel), 32'd0);
        idle(3);
        step(mk(1, 1, 2, 3, 1, 0), 0);
        step(mk(1, 9, 10, 11, 1, 0), 0);
        step(mk(1, 3, 5, 4, 1, 0), 0);
        step(nop(), 0);
        chk("memwb_a", 32'(fwd_a_sel), 32'd2);
        idle(3);

        // Load-use: one stall, then WB forwarding on both operands
        step(mk(1, 1, 0, 6, 1, 1), 0);
        step(mk(1, 6, 6, 7, 1, 0), 0);
        chk("lu_stall", 32'(stall), 32'd1);
        step(mk(1, 6, 6, 7, 1, 0), 0);
        chk("lu_stall_once", 32'(stall), 32'd0);
        step(nop(), 0);
        chk("lu_fwd_a", 32'(fwd_a_sel), 32'd2);
        chk("lu_fwd_b", 32'(fwd_b_sel), 32'd2);
        idle(3);

        // MEM-over-WB priority
        step(mk(1, 1, 2, 8, 1, 0), 0);
        step(mk(1, 3, 4, 8, 1, 0), 0);
        step(mk(1, 8, 8, 9, 1, 0), 0);
        step(nop(), 0);
        chk("prio_a", 32'(fwd_a_sel), 32'd1);
        idle(3);

        // Register zero never forwarded nor stalled
        step(mk(1, 1, 2, 0, 1, 0), 0);
        step(mk(1, 0, 0, 5, 1, 0), 0);
        step(nop(), 0);
        chk("r0_sel", 32'(fwd_a_sel), 32'd0);
        step(mk(1, 1, 0, 0, 1, 1), 0);
        step(mk(1, 0, 0, 5, 1, 0), 0);
        chk("r0_stall", 32'(stall), 32'd0);
        idle(3);

        // Load-use killed by flush
        step(mk(1, 1, 0, 6, 1, 1), 0);
        step(mk(1, 6, 2, 7, 1, 0), 1);
        chk("fl_stall", 32'(stall), 32'd0);
        chk("fl_bubble", 32'(idex_bubble), 32'd1);
        idle(3);

        // Reset asserted mid-stall
        step(mk(1, 1, 2, 3, 1, 0), 0);
        step(mk(1, 1, 0, 9, 1, 1), 0);
        @(negedge clk);
        id_valid = 1; id_rs = 5'd9; id_rt = 5'd3; id_rd = 5'd10;
        id_regwrite = 1; id_memread = 0; flush = 0;
        #1 chk("mid_stall_pre", 32'(stall), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_stall", 32'(stall), 32'd0);
        chk("mid_rst_a", 32'(fwd_a_sel), 32'd0);
        chk("mid_rst_b", 32'(fwd_b_sel), 32'd0);
        model_reset();
        @(negedge clk) rst_n = 1'b1;
        id_valid = 0; flush = 0;

        // Three back-to-back load-use pairs
        for (int k = 0; k < 3; k++) begin
            step(mk(1, 1, 0, 6, 1, 1), 0);
            step(mk(1, 6, 6, 7, 1, 1), 0);
            step(mk(1, 6, 6, 7, 1, 1), 0);
        end
        idle(3);
`ifdef FWDCTL_PERF_EN
        @(negedge clk) chk("stall_cnt3", stall_cnt, 32'(model_stalls));
`endif

        // Random traffic; the front end re-presents ID while stalled
        held = 0;
        r = nop();
        for (int k = 0; k < 400; k++) begin
            bit fl;
            if (!held) begin
                r = mk($urandom_range(0, 9) != 0, $urandom_range(0, 7),
                       $urandom_range(0, 7), $urandom_range(0, 7),
                       $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0);
            end
            fl = ($urandom_range(0, 9) == 0);
            held = m_stall_for(r, fl);
            step(r, fl);
        end
        idle(3);
`ifdef FWDCTL_PERF_EN
        @(negedge clk) chk("stall_cnt", stall_cnt, 32'(model_stalls));
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    function automatic bit m_stall_for(ins_t i, bit fl);
        return stg[0].v && stg[0].ld && stg[0].rd != 0 && i.v && !fl &&
               ((stg[0].rd == i.rs) || (stg[0].rd == i.rt));
    endfunction

endmodule

// File: doc/fwd_hazard_ctrl.md
Name: fwd_hazard_ctrl

Overview:
Forwarding and load-use hazard controller for the 5-stage pipelined datapath. It tracks destination-register tags for the EX, MEM and WB stages in internal shift registers. It drives the 2-bit select lines of the two 32-bit 3:1 ALU-operand forwarding muxes in EX, and generates the stall/bubble controls for PC, IF/ID and ID/EX.

Parameters:
REG_ADDR_W, 5, register-address width; register 0 is hard-wired zero and never forwarded or tracked as a hazard.

Ports:
Clk  in  1  pipeline clock, rising edge
Rst_n  in  1  asynchronous active-low reset
id_valid  in  1  instruction in ID is real (not a bubble)
id_rs  in  REG_ADDR_W  ID source A
id_rt  in  REG_ADDR_W  ID source B
id_rd  in  REG_ADDR_W  ID destination (already muxed rt/rd/31)
id_regwrite  in  1  ID instruction writes the register file
id_memread  in  1  ID instruction is a load
flush  in  1  branch/jump resolved taken; ID instruction is wrong-path
fwd_a_sel  out  2  operand-A mux select: 00 regfile, 01 EX/MEM result, 10 MEM/WB result
fwd_b_sel  out  2  operand-B mux select, same encoding
stall  out  1  load-use stall this cycle
pc_write  out  1  = ~stall
ifid_write  out  1  = ~stall
idex_bubble  out  1  ID/EX loads a NOP this cycle (stall | flush)

Behaviour:
- State registers: EX {ex_v, ex_rs, ex_rt, ex_rd, ex_we, ex_ld}; MEM {mem_v, mem_rd, mem_we}; WB {wb_v, wb_rd, wb_we}.
- Rst_n low: all state registers clear asynchronously; valid bits are 0.
- Outputs after reset, until the first valid instruction: fwd_*_sel=00, stall=0, pc_write=1, ifid_write=1, idex_bubble=0.
- Rising edge of Clk:
  - MEM->WB and EX->MEM always shift.
  - If idex_bubble=1, EX loads a bubble (ex_v=0, ex_we=0, ex_ld=0).
  - Otherwise EX loads the ID fields, with ex_v=id_valid.
- Forwarding is combinational from EX state plus MEM/WB state, for the instruction currently in EX:
  - fwd_a_sel=01 if mem_v & mem_we & mem_rd!=0 & mem_rd==ex_rs.
  - Else fwd_a_sel=10 if wb_v & wb_we & wb_rd!=0 & wb_rd==ex_rs.
  - Else fwd_a_sel=00.
  - fwd_b_sel: identical rule using ex_rt.
  - The MEM stage (newer) has priority over WB when both match.
  - Encoding 11 is never produced.
  - Outputs are 00 whenever ex_v=0.
- Load-use stall (combinational): raw = ex_v & ex_ld & ex_rd!=0 & id_valid & (ex_rd==id_rs | ex_rd==id_rt).
- stall = raw & ~flush. A flush kills the dependent instruction, so there is no stall.
- A stall lasts exactly 1 cycle: the bubble clears ex_ld, so raw falls on the next cycle. The load then sits in MEM, and its data arrives through the WB path (sel 10) one cycle later.
- Latency: select and stall outputs are valid in the same cycle as the stage contents, with no added pipeline delay.
- A back-to-back load followed by a dependent load gives 1 stall cycle per pair.
- id_rs==id_rt==ex_rd (load destination) gives 1 stall, not 2.
- Rst_n asserted mid-stall: stall drops immediately; all in-flight tags are discarded.

Optional Feature:
FWDCTL_PERF_EN:
- Defined: adds output stall_cnt [31:0].
  - Increments on every Clk edge with stall=1.
  - Saturates at 32'hFFFF_FFFF.
  - Cleared by Rst_n.
- Undefined: the port and counter are absent; behaviour is otherwise identical.

Decomposition:
- Shared package pipe_pkg holds:
  - FWD_SEL_REGFILE=2'b00, FWD_SEL_EXMEM=2'b01, FWD_SEL_MEMWB=2'b10.
  - REG_ZERO=0.
  - The stage-tag struct {v, rd, we}.
- One natural sub-module: fwd_sel_unit. It is purely combinational, takes one source address plus the MEM and WB tags, and returns the 2-bit select. It is instantiated twice, once for operand A and once for operand B.

Test Plan:
1. Reset held then released, idle inputs -> fwd_a_sel=fwd_b_sel=00, stall=0, pc_write=1, idex_bubble=0.
2. Issue add $3,$1,$2 then sub $4,$3,$5 on consecutive cycles -> when sub is in EX, fwd_a_sel=01 and fwd_b_sel=00. Issue an independent instruction between them instead -> fwd_a_sel=10.
3. Issue lw $6,0($1) then add $7,$6,$6 -> stall=1 and idex_bubble=1 for exactly 1 cycle. The add then enters EX with fwd_a_sel=fwd_b_sel=10.
4. Issue add $8,.. and then or $8,.., both writing $8, followed by a reader of $8 -> the reader sees sel=01, confirming MEM-over-WB priority.
5. Issue any instruction writing $0 followed by a reader of $0 -> sel=00. lw $0 followed by a reader of $0 -> stall=0.
6. Load-use hazard with flush=1 in the same cycle -> stall=0 and idex_bubble=1. Rst_n pulsed low during a stall cycle -> stall drops immediately and all sels=00. With FWDCTL_PERF_EN defined, stall_cnt counts 3 after three scenario-3 sequences.
